// File: rtl/pd_pl_pkg.sv
// Shared types and constants for the USB-PD protocol-layer transmit controller.
package pd_pl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_ARM_RX,
        ST_WAIT_CRC,
        ST_REPORT
    } tx_state_e;

    localparam logic [1:0] RES_ACK     = 2'd0;
    localparam logic [1:0] RES_DISCARD = 2'd1;
    localparam logic [1:0] RES_FAIL    = 2'd2;

    localparam logic [15:0] CRC_TIMEOUT_CYC_DEF = 16'd12000;

endpackage

// File: rtl/pd_crc_rx_timer.sv
// CRCReceiveTimer: clear has priority over enable; expire flags the last counted cycle.
module pd_crc_rx_timer #(
    parameter logic [15:0] LIMIT = 16'd12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == LIMIT - 16'd1);

endmodule

// File: rtl/pd_pl_tx_ctrl.sv
// Protocol-layer transmit controller: send, arm receiver, wait for GoodCRC, retry, report.
// Optional macro PD_PL_TX_RETRY_EN enables retransmission after CRCReceiveTimer expiry.
module pd_pl_tx_ctrl
    import pd_pl_pkg::*;
#(
    parameter logic [15:0] CRC_TIMEOUT_CYC = CRC_TIMEOUT_CYC_DEF,
    parameter logic [1:0]  N_RETRY         = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pe_tx_req,
    input  logic [2:0] pe_tx_type,
    input  logic       pe_soft_reset,
    output logic       pl_tx_done,
    output logic [1:0] pl_tx_result,
    output logic [2:0] pl_tx_msg_id,
    output logic       PL2PHY_Tx_Packet_en,
    output logic [2:0] PL2PHY_Tx_Packet_type,
    input  logic       PHY2PL_Tx_Packet_done,
    input  logic       PHY2PL_Tx_Packet_result,
    output logic       PL2PHY_Rx_Packet_select,
    input  logic       rx_goodcrc_valid,
    input  logic [2:0] rx_goodcrc_msg_id
);

    tx_state_e  state_q, state_d;
    logic [2:0] type_q, type_d;
    logic [2:0] msg_id_q, msg_id_d;
    logic [1:0] result_q, result_d;
    logic       done_q, done_d;
    logic       tx_en_q, tx_en_d;
    logic       rx_sel_q, rx_sel_d;
`ifdef PD_PL_TX_RETRY_EN
    logic [1:0] retry_q, retry_d;
`endif

    logic crc_match;
    logic timer_clr;
    logic timer_en;
    logic timer_expire;

    assign timer_clr = (state_q == ST_ARM_RX) || pe_soft_reset;
    assign timer_en  = (state_q == ST_WAIT_CRC);

    pd_crc_rx_timer #(
        .LIMIT (CRC_TIMEOUT_CYC)
    ) u_crc_rx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        msg_id_d = msg_id_q;
        result_d = result_q;
`ifdef PD_PL_TX_RETRY_EN
        retry_d  = retry_q;
`endif
        crc_match = rx_goodcrc_valid && (rx_goodcrc_msg_id == msg_id_q);

        case (state_q)
            ST_IDLE: begin
                if (pe_tx_req) begin
                    type_d  = pe_tx_type;
`ifdef PD_PL_TX_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (PHY2PL_Tx_Packet_done) begin
                    if (PHY2PL_Tx_Packet_result) begin
                        result_d = RES_DISCARD;
                        state_d  = ST_REPORT;
                    end else begin
                        state_d  = ST_ARM_RX;
                    end
                end
            end
            ST_ARM_RX: begin
                state_d = ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                // A matching GoodCRC takes precedence over a coincident timeout.
                if (crc_match) begin
                    result_d = RES_ACK;
                    state_d  = ST_REPORT;
                end else if (timer_expire) begin
`ifdef PD_PL_TX_RETRY_EN
                    if (retry_q < N_RETRY) begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_SEND;
                    end else begin
                        result_d = RES_FAIL;
                        state_d  = ST_REPORT;
                    end
`else
                    result_d = RES_FAIL;
                    state_d  = ST_REPORT;
`endif
                end
            end
            ST_REPORT: begin
                if (result_q != RES_DISCARD) begin
                    msg_id_d = msg_id_q + 3'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pe_soft_reset) begin
            state_d  = ST_IDLE;
            msg_id_d = '0;
        end

        // Output flops follow the next state so each output is aligned with its state.
        tx_en_d  = (state_d == ST_SEND);
        rx_sel_d = (state_d == ST_ARM_RX);
        done_d   = (state_d == ST_REPORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            type_q   <= '0;
            msg_id_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            tx_en_q  <= 1'b0;
            rx_sel_q <= 1'b0;
`ifdef PD_PL_TX_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            msg_id_q <= msg_id_d;
            result_q <= result_d;
            done_q   <= done_d;
            tx_en_q  <= tx_en_d;
            rx_sel_q <= rx_sel_d;
`ifdef PD_PL_TX_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    assign pl_tx_done              = done_q;
    assign pl_tx_result            = result_q;
    assign pl_tx_msg_id            = msg_id_q;
    assign PL2PHY_Tx_Packet_en     = tx_en_q;
    assign PL2PHY_Tx_Packet_type   = type_q;
    assign PL2PHY_Rx_Packet_select = rx_sel_q;

endmodule
